// File: rtl/vga_scan.sv
// vga_scan: VGA raster timing generator with a line-fetch handshake.
// hc/vc walk the raster (active, front porch, sync, back porch) and drive the
// fetch side (advance/newline/repeat_line/line) straight from the counters.
// The matching blanking/sync decodes travel down a FETCH_LAT-deep shift
// register so that they line up with the pixel word coming back from the
// fetcher. They are then registered together with the colour data.
// The replay port is named repeat_line because 'repeat' is a reserved word.
module vga_scan #(
    parameter int BPP         = 4,
    parameter int H_ACTIVE    = 640,
    parameter int H_FRONT     = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BACK      = 48,
    parameter int V_ACTIVE    = 480,
    parameter int V_FRONT     = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BACK      = 33,
    parameter bit HS_POL      = 1'b0,
    parameter bit VS_POL      = 1'b0,
    parameter int SCALE_SHIFT = 1,
    parameter int FETCH_LAT   = 1,
    parameter int LINE_W      = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    output logic                 hs,
    output logic                 vs,
    output logic                 fr,
    output logic [BPP-1:0]       r,
    output logic [BPP-1:0]       g,
    output logic [BPP-1:0]       b,
    output logic                 newline,
    output logic                 repeat_line,
    output logic                 advance,
    output logic [LINE_W-1:0]    line,
    input  logic [3*BPP-1:0]     pixel
);

    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    // Decode bounds, all resolved at elaboration time.
    localparam logic [11:0] H_DE_END = 12'(H_ACTIVE);
    localparam logic [11:0] H_SY_BEG = 12'(H_ACTIVE + H_FRONT);
    localparam logic [11:0] H_SY_END = 12'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [11:0] H_LAST   = 12'(H_TOTAL - 1);
    localparam logic [11:0] V_DE_END = 12'(V_ACTIVE);
    localparam logic [11:0] V_SY_BEG = 12'(V_ACTIVE + V_FRONT);
    localparam logic [11:0] V_SY_END = 12'(V_ACTIVE + V_FRONT + V_SYNC);
    localparam logic [11:0] V_LAST   = 12'(V_TOTAL - 1);

    // Low vc bits that select which replay of a source line is on screen.
    localparam logic [11:0] SCALE_MASK = 12'((1 << SCALE_SHIFT) - 1);

    // Parameter sanity: refuse to build a raster that cannot exist.
    if (H_ACTIVE == 0 || H_FRONT == 0 || H_SYNC == 0 || H_BACK == 0) begin : g_bad_h
        $error("vga_scan: horizontal timing parameters must be nonzero");
    end
    if (V_ACTIVE == 0 || V_FRONT == 0 || V_SYNC == 0 || V_BACK == 0) begin : g_bad_v
        $error("vga_scan: vertical timing parameters must be nonzero");
    end
    if (H_TOTAL > 4095 || V_TOTAL > 4095) begin : g_bad_total
        $error("vga_scan: H_TOTAL and V_TOTAL must not exceed 4095");
    end
    if (SCALE_SHIFT < 0 || SCALE_SHIFT > 3) begin : g_bad_scale
        $error("vga_scan: SCALE_SHIFT must be in 0..3");
    end
    if (FETCH_LAT < 0 || FETCH_LAT > 4) begin : g_bad_lat
        $error("vga_scan: FETCH_LAT must be in 0..4");
    end
    if (LINE_W < 1 || LINE_W + SCALE_SHIFT > 12) begin : g_bad_line
        $error("vga_scan: LINE_W must be >= 1 and fit in vc above SCALE_SHIFT");
    end
    if (BPP < 1) begin : g_bad_bpp
        $error("vga_scan: BPP must be at least 1");
    end

    logic [11:0] hc;
    logic [11:0] vc;
    logic        hc_last;
    logic        vc_last;
    logic        de0;
    logic        hs0;
    logic        vs0;
    logic        v_act;
    logic        line_start;
    logic        scale_first;
    logic [11:0] vc_src;

    logic        de_d;
    logic        hs_d;
    logic        vs_d;

    // End-of-line / end-of-frame detection.
    always_comb begin
        hc_last = (hc == H_LAST);
        vc_last = (vc == V_LAST);
    end

    // Raster counters: hc every cycle, vc on each hc wrap, both wrap together.
    always_ff @(posedge clk) begin
        if (reset) begin
            hc <= '0;
            vc <= '0;
        end else if (hc_last) begin
            hc <= '0;
            vc <= vc_last ? 12'd0 : vc + 12'd1;
        end else begin
            hc <= hc + 12'd1;
        end
    end

    // Stage-0 decodes taken directly from the current counter state.
    always_comb begin
        v_act       = (vc < V_DE_END);
        de0         = (hc < H_DE_END) && v_act;
        hs0         = (hc >= H_SY_BEG) && (hc < H_SY_END);
        vs0         = (vc >= V_SY_BEG) && (vc < V_SY_END);
        line_start  = (hc == 12'd0);
        scale_first = ((vc & SCALE_MASK) == 12'd0);
        vc_src      = vc >> SCALE_SHIFT;
    end

    // Fetch-side requests; held quiet while reset is asserted so a fetcher
    // never sees a request from the zeroed counters before release.
    always_comb begin
        advance     = de0 && !reset;
        fr          = !reset && line_start && (vc == 12'd0);
        newline     = !reset && line_start && v_act && scale_first;
        repeat_line = !reset && line_start && v_act && !scale_first;
        line        = reset ? '0 : vc_src[LINE_W-1:0];
    end

    if (FETCH_LAT == 0) begin : g_no_lat
        // Pixel arrives in the same cycle as advance: no delay needed.
        always_comb begin
            de_d = de0;
            hs_d = hs0;
            vs_d = vs0;
        end
    end else begin : g_lat
        logic [FETCH_LAT-1:0] de_sr;
        logic [FETCH_LAT-1:0] hs_sr;
        logic [FETCH_LAT-1:0] vs_sr;

        // Delay the decodes by the fetch latency; bit 0 is the youngest stage.
        always_ff @(posedge clk) begin
            if (reset) begin
                de_sr <= '0;
                hs_sr <= '0;
                vs_sr <= '0;
            end else begin
                de_sr <= FETCH_LAT'({de_sr, de0});
                hs_sr <= FETCH_LAT'({hs_sr, hs0});
                vs_sr <= FETCH_LAT'({vs_sr, vs0});
            end
        end

        // Oldest stage lines up with the pixel returned for that advance.
        always_comb begin
            de_d = de_sr[FETCH_LAT-1];
            hs_d = hs_sr[FETCH_LAT-1];
            vs_d = vs_sr[FETCH_LAT-1];
        end
    end

    // Output register: sync and colour leave together so they stay aligned.
    always_ff @(posedge clk) begin
        if (reset) begin
            hs <= ~HS_POL;
            vs <= ~VS_POL;
            r  <= '0;
            g  <= '0;
            b  <= '0;
        end else begin
            hs <= hs_d ? HS_POL : ~HS_POL;
            vs <= vs_d ? VS_POL : ~VS_POL;
            if (de_d) begin
                r <= pixel[3*BPP-1:2*BPP];
                g <= pixel[2*BPP-1:BPP];
                b <= pixel[BPP-1:0];
            end else begin
                r <= '0;
                g <= '0;
                b <= '0;
            end
        end
    end

endmodule

// File: tb/tb_vga_scan.sv
// tb_vga_scan: three small-raster instances (default latency/scale, deep
// latency with inverted sync, zero latency without scaling). The stimulus
// process drives reset/pixel and queues the expected outputs for each cycle;
// the monitor pops and compares on the falling edge.
module tb_vga_scan;

    localparam int HA = 8, HF = 2, HSY = 3, HB = 2;
    localparam int VA = 6, VF = 1, VSY = 2, VB = 1;
    localparam int HT = HA + HF + HSY + HB;   // 15
    localparam int VT = VA + VF + VSY + VB;   // 10

    localparam int LAT0 = 1, LAT1 = 4, LAT2 = 0;
    localparam int SS0  = 1, SS1  = 2, SS2  = 0;
    localparam bit HP0  = 1'b0, HP1 = 1'b1, HP2 = 1'b0;
    localparam bit VP0  = 1'b0, VP1 = 1'b1, VP2 = 1'b0;

    int LAT [3] = '{LAT0, LAT1, LAT2};
    int SS  [3] = '{SS0, SS1, SS2};
    bit HP  [3] = '{HP0, HP1, HP2};
    bit VP  [3] = '{VP0, VP1, VP2};

    typedef struct {
        bit         rst;
        bit         reg_chk;
        bit         adv;
        bit         fr;
        bit         nl;
        bit         rp;
        bit         line_chk;
        logic [7:0] line;
        bit         hs;
        bit         vs;
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } exp_t;

    exp_t q [3][$];

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [11:0] pixel = 12'h000;

    logic [2:0]  hs_o, vs_o, fr_o, nl_o, rp_o, adv_o;
    logic [3:0]  r_o [3];
    logic [3:0]  g_o [3];
    logic [3:0]  b_o [3];
    logic [7:0]  line_o [3];

    int checks = 0;
    int errors = 0;
    int n = 0;
    bit prev_rst = 1'b0;

    always #5 clk = ~clk;

    vga_scan #(.BPP(4), .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HSY), .H_BACK(HB),
               .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VSY), .V_BACK(VB),
               .HS_POL(HP0), .VS_POL(VP0), .SCALE_SHIFT(SS0), .FETCH_LAT(LAT0), .LINE_W(8))
    u_dut0 (.clk(clk), .reset(reset), .hs(hs_o[0]), .vs(vs_o[0]), .fr(fr_o[0]),
            .r(r_o[0]), .g(g_o[0]), .b(b_o[0]), .newline(nl_o[0]), .repeat_line(rp_o[0]),
            .advance(adv_o[0]), .line(line_o[0]), .pixel(pixel));

    vga_scan #(.BPP(4), .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HSY), .H_BACK(HB),
               .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VSY), .V_BACK(VB),
               .HS_POL(HP1), .VS_POL(VP1), .SCALE_SHIFT(SS1), .FETCH_LAT(LAT1), .LINE_W(8))
    u_dut1 (.clk(clk), .reset(reset), .hs(hs_o[1]), .vs(vs_o[1]), .fr(fr_o[1]),
            .r(r_o[1]), .g(g_o[1]), .b(b_o[1]), .newline(nl_o[1]), .repeat_line(rp_o[1]),
            .advance(adv_o[1]), .line(line_o[1]), .pixel(pixel));

    vga_scan #(.BPP(4), .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HSY), .H_BACK(HB),
               .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VSY), .V_BACK(VB),
               .HS_POL(HP2), .VS_POL(VP2), .SCALE_SHIFT(SS2), .FETCH_LAT(LAT2), .LINE_W(8))
    u_dut2 (.clk(clk), .reset(reset), .hs(hs_o[2]), .vs(vs_o[2]), .fr(fr_o[2]),
            .r(r_o[2]), .g(g_o[2]), .b(b_o[2]), .newline(nl_o[2]), .repeat_line(rp_o[2]),
            .advance(adv_o[2]), .line(line_o[2]), .pixel(pixel));

    function automatic logic [11:0] pix(int k);
        int v;
        v = k * 97 + 13;
        return v[11:0];
    endfunction

    // Expected outputs of instance i in the cycle whose counter state is n
    // cycles after reset release (n is ignored for reset cycles).
    function automatic exp_t model(int i, int k, bit rst, bit prv);
        exp_t e;
        int hc, vc, m, hm, vm;
        bit de_m;
        logic [11:0] p;
        e = '{default: 0};
        e.rst = rst;
        e.hs  = ~HP[i];
        e.vs  = ~VP[i];
        e.line_chk = 1'b1;
        if (rst) begin
            e.reg_chk = prv;
        end else begin
            hc = k % HT;
            vc = (k / HT) % VT;
            e.adv = (hc < HA) && (vc < VA);
            e.fr  = (hc == 0) && (vc == 0);
            e.nl  = (hc == 0) && (vc < VA) && ((vc % (1 << SS[i])) == 0);
            e.rp  = (hc == 0) && (vc < VA) && ((vc % (1 << SS[i])) != 0);
            e.line_chk = (vc < VA);
            e.line = 8'(vc >> SS[i]);
            e.reg_chk = 1'b1;
            m = k - LAT[i] - 1;
            if (m >= 0) begin
                hm = m % HT;
                vm = (m / HT) % VT;
                de_m = (hm < HA) && (vm < VA);
                if (hm >= HA + HF && hm < HA + HF + HSY) e.hs = HP[i];
                if (vm >= VA + VF && vm < VA + VF + VSY) e.vs = VP[i];
                if (de_m) begin
                    p = pix(k - 1);
                    e.r = p[11:8];
                    e.g = p[7:4];
                    e.b = p[3:0];
                end
            end
        end
        return e;
    endfunction

    task automatic chk(string nm, int i, int act, int want);
        checks++;
        if (act != want) begin
            errors++;
            $display("FAIL %s dut%0d t=%0t got %0d expected %0d", nm, i, $time, act, want);
        end
    endtask

    task automatic cyc(bit rv);
        @(posedge clk);
        #1;
        reset = rv;
        pixel = rv ? 12'h000 : pix(n);
        for (int i = 0; i < 3; i++) q[i].push_back(model(i, n, rv, prev_rst));
        prev_rst = rv;
        n = rv ? 0 : n + 1;
    endtask

    // Monitor: pops one expectation per instance per cycle and compares.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                if (q[i].size() > 0) begin
                    e = q[i].pop_front();
                    chk("advance", i, int'(adv_o[i]), int'(e.adv));
                    chk("fr", i, int'(fr_o[i]), int'(e.fr));
                    chk("newline", i, int'(nl_o[i]), int'(e.nl));
                    chk("repeat", i, int'(rp_o[i]), int'(e.rp));
                    if (e.line_chk) chk("line", i, int'(line_o[i]), int'(e.line));
                    if (e.reg_chk) begin
                        chk("hs", i, int'(hs_o[i]), int'(e.hs));
                        chk("vs", i, int'(vs_o[i]), int'(e.vs));
                        chk("r", i, int'(r_o[i]), int'(e.r));
                        chk("g", i, int'(g_o[i]), int'(e.g));
                        chk("b", i, int'(b_o[i]), int'(e.b));
                    end
                end
            end
        end
    end

    // Hand-computed frame period (15*10) and hsync width (3) on every instance.
    initial begin
        int since_fr [3] = '{-1, -1, -1};
        int hs_run [3] = '{0, 0, 0};
        forever begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                if (reset) begin
                    since_fr[i] = -1;
                    hs_run[i] = 0;
                end else begin
                    if (since_fr[i] >= 0) since_fr[i]++;
                    if (fr_o[i]) begin
                        if (since_fr[i] > 0) chk("fr_period", i, since_fr[i], 150);
                        since_fr[i] = 0;
                    end
                    if (hs_o[i] == HP[i]) begin
                        hs_run[i]++;
                    end else if (hs_run[i] > 0) begin
                        chk("hs_width", i, hs_run[i], 3);
                        hs_run[i] = 0;
                    end
                end
            end
        end
    end

    initial begin
        for (int k = 0; k < 3; k++) cyc(1'b1);
        for (int k = 0; k < 350; k++) cyc(1'b0);
        cyc(1'b1);                       // lands at hc=5, vc=3
        for (int k = 0; k < 200; k++) cyc(1'b0);
        for (int k = 0; k < 2; k++) cyc(1'b1);
        for (int k = 0; k < 160; k++) cyc(1'b0);
        repeat (3) @(posedge clk);
        for (int i = 0; i < 3; i++) chk("queue_drain", i, q[i].size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
